// File: rtl/divisor_secuencial.sv
// ============================================================================
// divisor_secuencial : W-bit unsigned restoring divider, one quotient bit/clk
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module divisor_secuencial #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] conta_num,
  input  logic [W-1:0] conta_den,
  output logic [W-1:0] cociente,
  output logic [W-1:0] resto,
  output logic         busy,
  output logic         done,
  output logic         div_cero
);

  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_nx;
  logic [W-1:0]   r_dvd;
  logic [W-1:0]   r_dvs;
  logic [W-1:0]   r_quo;
  logic [W:0]     r_rem;
  logic [CW-1:0]  r_cnt;
  logic           r_zero;
  logic           r_zhold;
  logic [W-1:0]   r_coc;
  logic [W-1:0]   r_res;
  logic           r_done;
  logic           r_dz;
  logic [W:0]     w_rem_sh;
  logic [W:0]     w_rem_nx;
  logic           w_ge;

  // One restoring step, W+1 bits wide so the compare/subtract cannot overflow
  assign w_rem_sh = {r_rem[W-1:0], r_dvd[W-1]};
  assign w_ge     = (w_rem_sh >= {1'b0, r_dvs});
  assign w_rem_nx = w_ge ? (w_rem_sh - {1'b0, r_dvs}) : w_rem_sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nx = (conta_den == '0) ? S_FIN : S_CALC;
        end
      end
      S_CALC: begin
        if (r_cnt == '0) begin
          w_state_nx = S_FIN;
        end
      end
      S_FIN: begin
        if (!r_zhold) begin
          w_state_nx = S_IDLE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dvd   <= '0;
      r_dvs   <= '0;
      r_quo   <= '0;
      r_rem   <= '0;
      r_cnt   <= '0;
      r_zero  <= 1'b0;
      r_zhold <= 1'b0;
      r_coc   <= '0;
      r_res   <= '0;
      r_done  <= 1'b0;
      r_dz    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_dvd   <= conta_num;
            r_dvs   <= conta_den;
            r_rem   <= '0;
            r_quo   <= '0;
            r_cnt   <= CW'(W - 1);
            r_zero  <= (conta_den == '0);
            r_zhold <= (conta_den == '0);
          end
        end
        S_CALC: begin
          r_rem <= w_rem_nx;
          r_dvd <= {r_dvd[W-2:0], 1'b0};
          r_quo <= {r_quo[W-2:0], w_ge};
          r_cnt <= r_cnt - CW'(1);
        end
        S_FIN: begin
          // Divide-by-zero spends one extra FIN cycle so results land two edges after acceptance
          if (r_zhold) begin
            r_zhold <= 1'b0;
          end else begin
            r_done <= 1'b1;
            if (r_zero) begin
              r_coc <= '1;
              r_res <= r_dvd;
              r_dz  <= 1'b1;
            end else begin
              r_coc <= r_quo;
              r_res <= r_rem[W-1:0];
              r_dz  <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign cociente = r_coc;
  assign resto    = r_res;
  assign busy     = (r_state != S_IDLE);
  assign done     = r_done;
  assign div_cero = r_dz;

endmodule

`default_nettype wire

// File: tb/tb_divisor_secuencial.sv
// ============================================================================
// tb_divisor_secuencial : directed + random + exhaustive checks vs. arithmetic model
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_divisor_secuencial;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] conta_num = '0;
  logic [W-1:0] conta_den = '0;
  logic [W-1:0] cociente;
  logic [W-1:0] resto;
  logic         busy;
  logic         done;
  logic         div_cero;

  int n_assert = 0;
  int n_fail   = 0;

  divisor_secuencial #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .conta_num (conta_num),
    .conta_den (conta_den),
    .cociente  (cociente),
    .resto     (resto),
    .busy      (busy),
    .done      (done),
    .div_cero  (div_cero)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void ref_div(input int n, input int d, output int q, output int r,
                                  output int z, output int lat);
    if (d == 0) begin
      q = (1 << W) - 1;
      r = n;
      z = 1;
      lat = 2;
    end else begin
      q = n / d;
      r = n % d;
      z = 0;
      lat = W + 1;
    end
  endfunction

  task automatic run_div(input int n, input int d, input string tag);
    int lat, nb, q, r, z, elat;
    bit got;
    @(negedge clk);
    conta_num = n[W-1:0];
    conta_den = d[W-1:0];
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    nb  = busy ? 1 : 0;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) got = 1'b1;
      else if (busy) nb++;
    end
    ref_div(n, d, q, r, z, elat);
    check($sformatf("%s latency", tag), lat, elat);
    check($sformatf("%s busy cycles", tag), nb, elat);
    check($sformatf("%s cociente", tag), {28'd0, cociente}, q);
    check($sformatf("%s resto", tag), {28'd0, resto}, r);
    check($sformatf("%s div_cero", tag), {31'd0, div_cero}, z);
  endtask

  initial begin
    int nd, last, q4, r4;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset cociente", {28'd0, cociente}, 0);
    check("reset resto", {28'd0, resto}, 0);
    check("reset busy", {31'd0, busy}, 0);
    check("reset done", {31'd0, done}, 0);
    check("reset div_cero", {31'd0, div_cero}, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle without start", {31'd0, busy}, 0);

    // Basic and corner divisions
    run_div(13, 4, "13/4");
    @(posedge clk);
    #1;
    check("done pulse width", {31'd0, done}, 0);
    run_div(15, 1, "15/1");
    run_div(3, 7, "3/7");
    run_div(15, 15, "15/15");
    run_div(0, 5, "0/5");

    // Divide by zero then recovery
    run_div(9, 0, "9/0");
    run_div(8, 2, "8/2");

    // Start while busy is ignored
    @(negedge clk);
    conta_num = 4'd13;
    conta_den = 4'd4;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    conta_num = 4'd6;
    conta_den = 4'd3;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    conta_num = 4'd7;
    conta_den = 4'd1;
    nd = 0;
    q4 = -1;
    r4 = -1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        nd++;
        q4 = int'(cociente);
        r4 = int'(resto);
      end
    end
    check("busy-start done count", nd, 1);
    check("busy-start cociente", q4, 3);
    check("busy-start resto", r4, 1);

    // Back-to-back with start held high
    @(negedge clk);
    conta_num = 4'd12;
    conta_den = 4'd5;
    start     = 1'b1;
    nd   = 0;
    last = 0;
    for (int e = 1; e <= 36; e++) begin
      @(posedge clk);
      #1;
      if (done) begin
        nd++;
        check("b2b interval", e - last, W + 2);
        check("b2b cociente", {28'd0, cociente}, 2);
        check("b2b resto", {28'd0, resto}, 2);
        last = e;
      end
      if (e == 36) start = 1'b0;
    end
    check("b2b done count", nd, 6);
    repeat (8) @(posedge clk);
    #1;
    check("b2b settles idle", {31'd0, busy}, 0);

    // Asynchronous reset in the middle of a division
    @(negedge clk);
    conta_num = 4'd14;
    conta_den = 4'd3;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midreset cociente", {28'd0, cociente}, 0);
    check("midreset resto", {28'd0, resto}, 0);
    check("midreset busy", {31'd0, busy}, 0);
    check("midreset div_cero", {31'd0, div_cero}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) nd++;
    end
    check("no done after reset", nd, 0);
    run_div(14, 3, "14/3 after reset");

    // Random operands
    for (int i = 0; i < 40; i++) begin
      int n, d;
      n = int'($urandom_range(0, (1 << W) - 1));
      d = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, (1 << W) - 1));
      run_div(n, d, $sformatf("rand %0d/%0d", n, d));
    end

    // Exhaustive sweep
    for (int n = 0; n < (1 << W); n++) begin
      for (int d = 0; d < (1 << W); d++) begin
        run_div(n, d, $sformatf("sweep %0d/%0d", n, d));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
